// File: rtl/turbo_codec_scheduler.sv
// Round-robin scheduler sharing one turbo codec engine between an encode and a decode requester.
// Each grant sequences GRANT -> FEED -> WAIT -> DONE, with a watchdog on the engine's valid pulse.
module turbo_codec_scheduler #(
    parameter int ENC_FEED = 8,
    parameter int DEC_FEED = 1,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_req,
    input  logic       enc_din,
    output logic       enc_gnt,
    output logic       enc_done,
    input  logic       dec_req,
    input  logic [2:0] dec_sym,
    output logic       dec_gnt,
    output logic       dec_done,
    output logic       eng_start,
    output logic       eng_mode,
    output logic [2:0] eng_sym,
    input  logic       eng_valid,
    output logic       timeout_err,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_FEED, S_WAIT, S_DONE} state_e;

    localparam logic [CNT_W-1:0] ENC_LOAD = CNT_W'(ENC_FEED - 1);
    localparam logic [CNT_W-1:0] DEC_LOAD = CNT_W'(DEC_FEED - 1);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enc_sel_q, enc_sel_d;   // 1: current frame belongs to the encoder
    logic             rr_enc_q, rr_enc_d;     // 1: encoder was served last
    logic             to_q, to_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            enc_sel_q   <= 1'b0;
            rr_enc_q    <= 1'b0;
            to_q        <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            enc_sel_q   <= enc_sel_d;
            rr_enc_q    <= rr_enc_d;
            to_q        <= to_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enc_sel_d   = enc_sel_q;
        rr_enc_d    = rr_enc_q;
        to_d        = to_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                to_d = 1'b0;
                // On a tie the requester not served last wins.
                if (enc_req && (!dec_req || !rr_enc_q)) begin
                    enc_sel_d = 1'b1;
                    state_d   = S_GRANT;
                end else if (dec_req) begin
                    enc_sel_d = 1'b0;
                    state_d   = S_GRANT;
                end
            end
            S_GRANT: begin
                cnt_d   = enc_sel_q ? ENC_LOAD : DEC_LOAD;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (cnt_q == '0) begin
                    cnt_d   = TO_LOAD;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                // A valid on the last watchdog cycle still counts as success.
                if (eng_valid) begin
                    state_d = S_DONE;
                end else if (cnt_q == '0) begin
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                rr_enc_d    = enc_sel_q;
                to_d        = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset clears them without a clock.
    assign busy        = (state_q != S_IDLE);
    assign enc_gnt     = busy && enc_sel_q;
    assign dec_gnt     = busy && !enc_sel_q;
    assign eng_mode    = enc_gnt;
    assign eng_start   = (state_q == S_FEED);
    assign eng_sym     = !eng_start ? 3'b000 : (enc_sel_q ? {2'b00, enc_din} : dec_sym);
    assign enc_done    = (state_q == S_DONE) && enc_sel_q;
    assign dec_done    = (state_q == S_DONE) && !enc_sel_q;
    assign timeout_err = (state_q == S_DONE) && to_q;
    assign frame_cnt   = frame_cnt_q;

    gnt_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(enc_gnt && dec_gnt));

endmodule

// File: tb/tb_turbo_codec_scheduler.sv
// Bench for turbo_codec_scheduler: frame-timeline model checked every cycle plus directed literal checks.
module tb_turbo_codec_scheduler;

    localparam int ENC_FEED = 8;
    localparam int DEC_FEED = 1;
    localparam int TIMEOUT  = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enc_req, enc_din, dec_req, eng_valid;
    logic [2:0] dec_sym;
    logic       enc_gnt, enc_done, dec_gnt, dec_done;
    logic       eng_start, eng_mode, timeout_err, busy;
    logic [2:0] eng_sym;
    logic [7:0] frame_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    turbo_codec_scheduler #(.ENC_FEED(ENC_FEED), .DEC_FEED(DEC_FEED), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .enc_req(enc_req), .enc_din(enc_din), .enc_gnt(enc_gnt), .enc_done(enc_done),
        .dec_req(dec_req), .dec_sym(dec_sym), .dec_gnt(dec_gnt), .dec_done(dec_done),
        .eng_start(eng_start), .eng_mode(eng_mode), .eng_sym(eng_sym), .eng_valid(eng_valid),
        .timeout_err(timeout_err), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame model: a frame is a timeline counted from its GRANT cycle (t = 0).
    bit m_busy, m_enc, m_to, m_last_enc;
    int m_t, m_done_at, m_frames;
    // Observations used by directed checks.
    int       start_cnt, last_done_cyc, last_to;
    logic [7:0] sym_bits;
    logic [2:0] sym_last;
    bit       enc_gnt_seen, both_gnt_seen;
    bit       done_q[$];

    always @(negedge clk) begin
        int  feed;
        bit  e_start, e_done;
        logic [2:0] e_sym;
        if (!rst_n) begin
            m_busy = 0; m_enc = 0; m_to = 0; m_last_enc = 0;
            m_t = 0; m_done_at = -1; m_frames = 0;
            chk("reset_ctrl", int'({enc_gnt, dec_gnt, enc_done, dec_done, eng_start, eng_mode, timeout_err, busy}), 0);
            chk("reset_sym", int'(eng_sym), 0);
            chk("reset_frame_cnt", int'(frame_cnt), 0);
        end else begin
            feed    = m_enc ? ENC_FEED : DEC_FEED;
            e_start = m_busy && m_t >= 1 && m_t <= feed;
            e_done  = m_busy && m_t == m_done_at;
            e_sym   = !e_start ? 3'b000 : (m_enc ? {2'b00, enc_din} : dec_sym);
            chk("busy", int'(busy), int'(m_busy));
            chk("enc_gnt", int'(enc_gnt), int'(m_busy && m_enc));
            chk("dec_gnt", int'(dec_gnt), int'(m_busy && !m_enc));
            chk("eng_mode", int'(eng_mode), int'(m_busy && m_enc));
            chk("eng_start", int'(eng_start), int'(e_start));
            chk("eng_sym", int'(eng_sym), int'(e_sym));
            chk("enc_done", int'(enc_done), int'(e_done && m_enc));
            chk("dec_done", int'(dec_done), int'(e_done && !m_enc));
            chk("timeout_err", int'(timeout_err), int'(e_done && m_to));
            chk("frame_cnt", int'(frame_cnt), m_frames);

            if (eng_start) begin
                start_cnt++;
                sym_bits = {sym_bits[6:0], eng_sym[0]};
                sym_last = eng_sym;
            end
            if (enc_gnt) enc_gnt_seen = 1;
            if (enc_gnt && dec_gnt) both_gnt_seen = 1;
            if (enc_done || dec_done) begin
                done_q.push_back(enc_done);
                last_done_cyc = cyc;
                last_to       = int'(timeout_err);
            end

            if (!m_busy) begin
                if (enc_req || dec_req) begin
                    m_enc  = enc_req && (!dec_req || !m_last_enc);
                    m_busy = 1; m_t = 0; m_done_at = -1; m_to = 0;
                end
            end else if (m_t == m_done_at) begin
                m_busy     = 0;
                m_frames   = (m_frames + 1) % 256;
                m_last_enc = m_enc;
            end else begin
                if (m_t > feed && m_done_at < 0) begin
                    if (eng_valid) m_done_at = m_t + 1;
                    else if (m_t - feed == TIMEOUT) begin
                        m_done_at = m_t + 1;
                        m_to      = 1;
                    end
                end
                m_t++;
            end
        end
    end

    task automatic clr();
        start_cnt = 0; sym_bits = '0; sym_last = '0; last_to = -1; last_done_cyc = -1;
        enc_gnt_seen = 0; both_gnt_seen = 0; done_q.delete();
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Holds the requests until ndone done pulses; the engine stub answers vdelay cycles after the last start.
    task automatic run_frames(input bit e, input bit d, input logic [7:0] pat, input logic [2:0] sym,
                              input int vdelay, input bit vfeed, input int ndone, output int req_cyc);
        int since, bi, got;
        since = -1; bi = 0; got = 0;
        enc_req = e; dec_req = d; dec_sym = sym; req_cyc = cyc;
        for (int n = 0; n < ndone * 40 + 20 && got < ndone; n++) begin
            if (eng_start) since = 0;
            else if (since >= 0) since++;
            eng_valid = (vfeed && eng_start) || (!eng_start && vdelay > 0 && since == vdelay);
            enc_din   = (eng_start && eng_mode) ? pat[7 - (bi % 8)] : 1'b0;
            if (eng_start && eng_mode) bi++;
            if (enc_done || dec_done) begin
                got++;
                since = -1;
            end
            tick();
        end
        enc_req = 0; dec_req = 0; eng_valid = 0; enc_din = 0;
        chk("frames_completed_in_budget", got, ndone);
    endtask

    initial begin
        int rc;
        rst_n = 0; enc_req = 0; enc_din = 0; dec_req = 0; dec_sym = '0; eng_valid = 0;
        clr();
        repeat (3) tick();
        chk("reset_busy_lit", int'(busy), 0);
        chk("reset_frame_cnt_lit", int'(frame_cnt), 0);
        rst_n = 1;
        tick();

        // Single encode, valid two cycles after the last start: 1+1+8+2+1 cycles inclusive.
        clr();
        run_frames(1, 0, 8'b10110010, 3'b000, 2, 0, 1, rc);
        chk("enc_start_cycles", start_cnt, 8);
        chk("enc_pattern", int'(sym_bits), 8'hB2);
        chk("enc_latency", last_done_cyc - rc, 12);
        chk("enc_frame_cnt", int'(frame_cnt), 1);
        chk("enc_no_timeout", last_to, 0);

        // Single decode, valid five cycles after start.
        clr();
        run_frames(0, 1, 8'h00, 3'b101, 5, 0, 1, rc);
        chk("dec_start_cycles", start_cnt, 1);
        chk("dec_sym", int'(sym_last), 5);
        chk("dec_latency", last_done_cyc - rc, 8);
        chk("dec_done_count", done_q.size(), 1);
        chk("dec_no_enc_gnt", int'(enc_gnt_seen), 0);

        // Engine silent: 15 WAIT cycles then timeout.
        clr();
        run_frames(1, 0, 8'hFF, 3'b000, 0, 0, 1, rc);
        chk("to_latency", last_done_cyc - rc, 25);
        chk("to_flag", last_to, 1);
        chk("to_frame_cnt", int'(frame_cnt), 3);
        clr();
        run_frames(1, 0, 8'h0F, 3'b000, 1, 0, 1, rc);
        chk("after_to_latency", last_done_cyc - rc, 11);
        chk("after_to_flag", last_to, 0);

        // Valid on the last watchdog cycle wins over timeout.
        clr();
        run_frames(1, 0, 8'h5A, 3'b000, 15, 0, 1, rc);
        chk("edge_latency", last_done_cyc - rc, 25);
        chk("edge_flag", last_to, 0);

        // Valid during FEED is ignored.
        clr();
        run_frames(1, 0, 8'hA5, 3'b000, 3, 1, 1, rc);
        chk("feed_valid_latency", last_done_cyc - rc, 13);
        chk("feed_valid_flag", last_to, 0);
        chk("feed_valid_frame_cnt", int'(frame_cnt), 6);

        // Async reset during the fourth FEED cycle.
        clr();
        enc_req = 1;
        for (int n = 0; n < 30 && start_cnt < 3; n++) tick();
        chk("pre_reset_in_feed", int'(eng_start), 1);
        #2 rst_n = 0;
        #1;
        chk("async_eng_start", int'(eng_start), 0);
        chk("async_enc_gnt", int'(enc_gnt), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_no_done", int'(enc_done), 0);
        dec_req = 1;
        repeat (2) tick();
        rst_n = 1;
        chk("post_reset_frame_cnt", int'(frame_cnt), 0);

        // Contention held from reset: strict alternation starting with encode.
        clr();
        run_frames(1, 1, 8'hC3, 3'b110, 2, 0, 4, rc);
        chk("cont_frames", done_q.size(), 4);
        if (done_q.size() == 4) begin
            chk("cont_order0", int'(done_q[0]), 1);
            chk("cont_order1", int'(done_q[1]), 0);
            chk("cont_order2", int'(done_q[2]), 1);
            chk("cont_order3", int'(done_q[3]), 0);
        end
        chk("cont_frame_cnt", int'(frame_cnt), 4);
        chk("cont_no_overlap", int'(both_gnt_seen), 0);

        // 256 frames wrap the frame counter.
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        clr();
        run_frames(0, 1, 8'h00, 3'b011, 1, 0, 256, rc);
        chk("wrap_frames", done_q.size(), 256);
        chk("wrap_frame_cnt", int'(frame_cnt), 0);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
